// File: rtl/pll_lock_supervisor_pkg.sv
// PLL lock supervisor shared types and helpers.
// Channel FSM states and the timer width function.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } sup_state_e;

  // One timer serves both the reset pulse and the lock timeout.
  function automatic int tmr_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_chan.sv
// One supervised PLL: lock synchroniser, glitch filter, reset/retry FSM.
// Ports: clk, rst_n, enable, clr_err, pll_lock_in -> pll_rst_out, locked, err, fail, lock_lost_pulse, loss_cnt.
module pll_lock_supervisor_chan
  import pll_lock_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES  = 3,
  parameter int FILT_LEN     = 4,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_err,
  input  logic             pll_lock_in,
  output logic             pll_rst_out,
  output logic             locked,
  output logic             err,
  output logic             fail,
  output logic             lock_lost_pulse,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int TW = tmr_w(RST_PULSE, LOCK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;

  sup_state_e             state_q;
  logic [TW-1:0]          tmr_q;
  logic [RW-1:0]          retry_q;
  logic [RW-1:0]          retry_inc;
  logic                   rst_q;
  logic                   locked_q;
  logic                   err_q;
  logic                   fail_q;
  logic                   pulse_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;

  assign synced = sync_q[SYNC_STAGES-1];

  // Filter flips on the FILT_LEN-th consecutive opposite sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (synced != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_in};
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign retry_inc = retry_q + RW'(1);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // FSM reacts to filt_d so locked tracks the filter edge in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      retry_q  <= '0;
      rst_q    <= 1'b1;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      fail_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (clr_err) begin
        err_q  <= 1'b0;
        fail_q <= 1'b0;
        cnt_q  <= '0;
      end
      if (!enable) begin
        state_q  <= ST_IDLE;
        retry_q  <= '0;
        rst_q    <= 1'b1;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_RST;
            tmr_q   <= '0;
            rst_q   <= 1'b1;
          end
          ST_RST: begin
            if (tmr_q == TW'(RST_PULSE - 1)) begin
              state_q <= ST_WAIT;
              tmr_q   <= '0;
              rst_q   <= 1'b0;
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_WAIT: begin
            if (filt_d) begin
              state_q  <= ST_LOCKED;
              retry_q  <= '0;
              locked_q <= 1'b1;
            end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
              tmr_q   <= '0;
              retry_q <= retry_inc;
              rst_q   <= 1'b1;
              if (retry_inc == RW'(MAX_RETRY)) begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= ST_RST;
              end
            end else begin
              tmr_q <= tmr_q + TW'(1);
            end
          end
          ST_LOCKED: begin
            if (!filt_d) begin
              state_q  <= ST_RST;
              tmr_q    <= '0;
              retry_q  <= '0;
              rst_q    <= 1'b1;
              locked_q <= 1'b0;
              pulse_q  <= 1'b1;
              err_q    <= 1'b1;
              // A coincident clear restarts the count at this loss.
              cnt_q    <= clr_err ? CNT_W'(1) : cnt_inc;
            end
          end
          ST_FAIL: begin
            if (clr_err) begin
              state_q <= ST_RST;
              tmr_q   <= '0;
              retry_q <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            rst_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pll_rst_out     = rst_q;
  assign locked          = locked_q;
  assign err             = err_q;
  assign fail            = fail_q;
  assign lock_lost_pulse = pulse_q;
  assign loss_cnt        = cnt_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Multi-channel PLL lock supervisor: NUM_CH independent channels.
// Ports: clk, rst_n, enable, clr_err, pll_lock_in -> per-channel status, loss_cnt, all_locked.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 3,
  parameter int FILT_LEN     = 4,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clr_err,
  input  logic [NUM_CH-1:0]       pll_lock_in,
  output logic [NUM_CH-1:0]       pll_rst_out,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH-1:0]       lock_lost_pulse,
  output logic [NUM_CH*CNT_W-1:0] loss_cnt,
  output logic                    all_locked
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_lock_supervisor_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_PULSE   (RST_PULSE),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .MAX_RETRY   (MAX_RETRY),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .clr_err        (clr_err),
      .pll_lock_in    (pll_lock_in[i]),
      .pll_rst_out    (pll_rst_out[i]),
      .locked         (locked[i]),
      .err            (err[i]),
      .fail           (fail[i]),
      .lock_lost_pulse(lock_lost_pulse[i]),
      .loss_cnt       (loss_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign all_locked = &locked;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor.
// Stimulus queues cycle-stamped output events; a monitor matches each output change.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clr_err;
  logic [1:0] pll_lock_in;
  logic [1:0] pll_rst_out;
  logic [1:0] locked;
  logic [1:0] err;
  logic [1:0] fail;
  logic [1:0] lock_lost_pulse;
  logic [3:0] loss_cnt;
  logic       all_locked;

  pll_lock_supervisor #(
    .NUM_CH      (2),
    .SYNC_STAGES (3),
    .FILT_LEN    (4),
    .RST_PULSE   (4),
    .LOCK_TIMEOUT(64),
    .MAX_RETRY   (2),
    .CNT_W       (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clr_err        (clr_err),
    .pll_lock_in    (pll_lock_in),
    .pll_rst_out    (pll_rst_out),
    .locked         (locked),
    .err            (err),
    .fail           (fail),
    .lock_lost_pulse(lock_lost_pulse),
    .loss_cnt       (loss_cnt),
    .all_locked     (all_locked)
  );

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // {pll_rst_out, locked, err, fail, lock_lost_pulse, loss_cnt[1:0]}
  function automatic logic [6:0] s(input logic r, input logic l,
                                   input logic e, input logic f,
                                   input logic p, input logic [1:0] c);
    return {r, l, e, f, p, c};
  endfunction

  function automatic logic [6:0] snap(input int ch);
    case (ch)
      0:       return {pll_rst_out[0], locked[0], err[0], fail[0],
                       lock_lost_pulse[0], loss_cnt[1:0]};
      1:       return {pll_rst_out[1], locked[1], err[1], fail[1],
                       lock_lost_pulse[1], loss_cnt[3:2]};
      default: return {6'b0, all_locked};
    endcase
  endfunction

  task automatic ex(input int ch, input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    case (ch)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_ev(input int ch, input logic [6:0] v);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (ch)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_event stream%0d: got cyc=%0d val=%b, required none",
               ch, cyc, v);
    end else if (e.cyc != cyc || e.v != v) begin
      errors++;
      $display("FAIL event stream%0d: got cyc=%0d val=%b, required cyc=%0d val=%b",
               ch, cyc, v, e.cyc, e.v);
    end
  endtask

  // Monitor: any change on a stream is an event to match.
  initial begin
    logic [6:0] prev [3];
    bit first;
    first = 1'b1;
    #7;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        logic [6:0] cur;
        cur = snap(ch);
        if (first || cur != prev[ch]) check_ev(ch, cur);
        prev[ch] = cur;
      end
      first = 1'b0;
    end
  end

  task automatic go(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic loss1(input int l, input logic [1:0] c);
    ex(1, l,     s(1, 0, 1, 0, 1, c));
    ex(1, l + 1, s(1, 0, 1, 0, 0, c));
    ex(1, l + 4, s(0, 0, 1, 0, 0, c));
    ex(2, l, 7'd0);
  endtask

  task automatic relock1(input int r, input logic [1:0] c);
    ex(1, r, s(0, 1, 1, 0, 0, c));
    ex(2, r, 7'd1);
  endtask

  task automatic drain(input int ch);
    exp_t e;
    forever begin
      case (ch)
        0: if (q0.size() > 0) e = q0.pop_front(); else return;
        1: if (q1.size() > 0) e = q1.pop_front(); else return;
        default: if (q2.size() > 0) e = q2.pop_front(); else return;
      endcase
      checks++;
      errors++;
      $display("FAIL missing_event stream%0d: got nothing, required cyc=%0d val=%b",
               ch, e.cyc, e.v);
    end
  endtask

  initial begin
    int n;
    logic [1:0] c;
    rst_n       = 1'b0;
    enable      = 1'b0;
    clr_err     = 1'b0;
    pll_lock_in = 2'b10;
    ex(0, 1, s(1, 0, 0, 0, 0, 0));
    ex(1, 1, s(1, 0, 0, 0, 0, 0));
    ex(2, 1, 7'd0);
    go(1);
    rst_n = 1'b1;

    // Bring-up: reset pulse then lock on both channels.
    go(10);
    enable = 1'b1;
    ex(0, 15, s(0, 0, 0, 0, 0, 0));
    ex(1, 15, s(0, 0, 0, 0, 0, 0));
    ex(1, 16, s(0, 1, 0, 0, 0, 0));
    go(25);
    pll_lock_in[0] = 1'b1;
    ex(0, 32, s(0, 1, 0, 0, 0, 0));
    ex(2, 32, 7'd1);

    // Short glitch ignored, long drop is a loss.
    go(40);
    pll_lock_in[0] = 1'b0;
    go(43);
    pll_lock_in[0] = 1'b1;
    go(50);
    pll_lock_in[0] = 1'b0;
    ex(0, 57, s(1, 0, 1, 0, 1, 1));
    ex(0, 58, s(1, 0, 1, 0, 0, 1));
    ex(0, 61, s(0, 0, 1, 0, 0, 1));
    ex(2, 57, 7'd0);
    go(60);
    pll_lock_in[0] = 1'b1;
    ex(0, 67, s(0, 1, 1, 0, 0, 1));
    ex(2, 67, 7'd1);

    // No lock: two timeouts then FAIL; clr_err restarts.
    go(80);
    pll_lock_in[0] = 1'b0;
    ex(0, 87,  s(1, 0, 1, 0, 1, 2));
    ex(0, 88,  s(1, 0, 1, 0, 0, 2));
    ex(0, 91,  s(0, 0, 1, 0, 0, 2));
    ex(0, 155, s(1, 0, 1, 0, 0, 2));
    ex(0, 159, s(0, 0, 1, 0, 0, 2));
    ex(0, 223, s(1, 0, 1, 1, 0, 2));
    ex(2, 87, 7'd0);
    go(230);
    clr_err = 1'b1;
    ex(0, 231, s(1, 0, 0, 0, 0, 0));
    ex(0, 235, s(0, 0, 0, 0, 0, 0));
    go(231);
    clr_err = 1'b0;
    go(240);
    pll_lock_in[0] = 1'b1;
    ex(0, 247, s(0, 1, 0, 0, 0, 0));
    ex(2, 247, 7'd1);

    // Counter saturation on ch1.
    for (int k = 0; k < 5; k++) begin
      n = 260 + 20 * k;
      c = (k >= 2) ? 2'd3 : 2'(k + 1);
      go(n);
      pll_lock_in[1] = 1'b0;
      loss1(n + 7, c);
      go(n + 10);
      pll_lock_in[1] = 1'b1;
      relock1(n + 17, c);
    end
    // clr_err coincident with the sixth loss.
    go(360);
    pll_lock_in[1] = 1'b0;
    loss1(367, 2'd1);
    go(366);
    clr_err = 1'b1;
    go(367);
    clr_err = 1'b0;
    go(370);
    pll_lock_in[1] = 1'b1;
    relock1(377, 2'd1);

    // Disable while locked, then re-enable.
    go(390);
    enable = 1'b0;
    ex(0, 391, s(1, 0, 0, 0, 0, 0));
    ex(1, 391, s(1, 0, 1, 0, 0, 1));
    ex(2, 391, 7'd0);
    go(400);
    enable = 1'b1;
    ex(0, 405, s(0, 0, 0, 0, 0, 0));
    ex(1, 405, s(0, 0, 1, 0, 0, 1));
    ex(0, 406, s(0, 1, 0, 0, 0, 0));
    ex(1, 406, s(0, 1, 1, 0, 0, 1));
    ex(2, 406, 7'd1);

    // Async reset in the middle of WAIT_LOCK.
    go(420);
    pll_lock_in[0] = 1'b0;
    ex(0, 427, s(1, 0, 1, 0, 1, 1));
    ex(0, 428, s(1, 0, 1, 0, 0, 1));
    ex(0, 431, s(0, 0, 1, 0, 0, 1));
    ex(2, 427, 7'd0);
    go(440);
    ex(0, 440, s(1, 0, 0, 0, 0, 0));
    ex(1, 440, s(1, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    go(445);
    rst_n = 1'b1;
    ex(0, 450, s(0, 0, 0, 0, 0, 0));
    ex(1, 450, s(0, 0, 0, 0, 0, 0));
    ex(1, 452, s(0, 1, 0, 0, 0, 0));

    go(470);
    #3;
    for (int ch = 0; ch < 3; ch++) drain(ch);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
